// File: rtl/key_entry_buffer_pkg.sv
// key_entry_buffer_pkg: key codes, FSM states and key classification shared by the entry buffer
package key_entry_buffer_pkg;
  localparam logic [4:0] KEY_HASH      = 5'h0E;
  localparam logic [4:0] KEY_STAR      = 5'h0F;
  localparam logic [4:0] KEY_NONE      = 5'd16;
  localparam logic [4:0] KEY_BAD       = 5'd17;
  localparam logic [4:0] KEY_LETTER_LO = 5'h0A;
  localparam logic [4:0] KEY_LETTER_HI = 5'h0D;
  typedef enum logic [1:0] {ST_EMPTY, ST_EDIT, ST_HOLD} state_t;
  typedef enum logic [1:0] {KC_DIGIT, KC_BACK, KC_CLEAR, KC_IGNORE} key_class_t;
  function automatic key_class_t classify(input logic [4:0] k);
    return ((k >= KEY_LETTER_LO && k <= KEY_LETTER_HI) || k == KEY_NONE || k == KEY_BAD) ? KC_IGNORE :
           k == KEY_STAR ? KC_BACK :
           k == KEY_HASH ? KC_CLEAR :
           k <= 5'd9     ? KC_DIGIT : KC_IGNORE;
  endfunction
endpackage

// File: rtl/key_entry_buffer_edge_detect.sv
// edge_detect: single-bit rising-edge detector; RST_VAL=1 suppresses a level already high at reset
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;
  always_comb prev_d = d;
  always_ff @(posedge clk) prev_q <= rst ? RST_VAL : prev_d;
  assign rise = d & ~prev_q;
endmodule

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: assembles keypad digits into a BCD entry and commits it via valid/ack
module key_entry_buffer
  import key_entry_buffer_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            digito,
  input  logic                  cambio_digito,
  input  logic                  enter_sync,
  input  logic                  value_ack,
  output logic [4*N_DIGITS-1:0] entry,
  output logic [3:0]            count,
  output logic [4*N_DIGITS-1:0] value,
  output logic                  value_valid,
  output logic                  overflow
);
  localparam int W = 4 * N_DIGITS;
  localparam logic [3:0] CNT_MAX = 4'(N_DIGITS);
  state_t state_q, state_d;
  key_class_t kc;
  logic [W-1:0] entry_q, entry_d, value_q, value_d;
  logic [3:0] count_q, count_d;
  logic valid_q, valid_d, ovf_q, ovf_d, key_ev, enter_ev;
  edge_detect #(.RST_VAL(1'b1)) u_key_ed (.clk(clk), .rst(rst), .d(cambio_digito), .rise(key_ev));
  edge_detect #(.RST_VAL(1'b1)) u_ent_ed (.clk(clk), .rst(rst), .d(enter_sync), .rise(enter_ev));
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    count_d = count_q;
    value_d = value_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    kc      = classify(digito);
    case (state_q)
      ST_EMPTY: if (key_ev && kc == KC_DIGIT) begin
        entry_d = W'(digito[3:0]);
        count_d = 4'd1;
        state_d = ST_EDIT;
      end
      ST_EDIT: if (enter_ev) begin
        value_d = entry_q;
        valid_d = 1'b1;
        entry_d = '0;
        count_d = '0;
        state_d = ST_HOLD;
      end else if (key_ev) begin
        case (kc)
          KC_DIGIT: if (count_q < CNT_MAX) begin
            entry_d = (entry_q << 4) | W'(digito[3:0]);
            count_d = count_q + 4'd1;
          end else ovf_d = 1'b1;
          KC_BACK: begin
            entry_d = entry_q >> 4;
            count_d = count_q - 4'd1;
            state_d = count_q == 4'd1 ? ST_EMPTY : ST_EDIT;
          end
          KC_CLEAR: begin
            entry_d = '0;
            count_d = '0;
            state_d = ST_EMPTY;
          end
          default: ;
        endcase
      end
      ST_HOLD: if (value_ack) begin
        valid_d = 1'b0;
        state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      entry_q <= '0;
      count_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      count_q <= count_d;
      value_q <= value_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
  assign entry       = entry_q;
  assign count       = count_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign overflow    = ovf_q;
endmodule
